// File: rtl/mem2wb_pipe_stage.sv
// mem2wb_pipe_stage: MEM->WB pipeline register with valid/ready flow control.
// Holds one entry in the main register and, when SKID_EN is set, one more in a
// skid register so that in_ready can come straight from a flop. Flush drops all
// held entries and turns the output into a bubble. A saturating counter records
// how many cycles write-back stalled while an entry was waiting.
module mem2wb_pipe_stage #(
  parameter int          PAYLOAD_W = 96,
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter bit          SKID_EN   = 1'b1,
  parameter int          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr_i,
  input  logic [31:0]          pc_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic                 regwrite_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr_o,
  output logic [31:0]          pc_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic                 regwrite_o,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state;
  logic                   out_valid_q;
  logic                   in_ready_q;
  logic [31:0]            instr_q;
  logic [31:0]            pc_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic                   regwrite_q;
  logic [31:0]            skid_instr;
  logic [31:0]            skid_pc;
  logic [PAYLOAD_W-1:0]   skid_payload;
  logic                   skid_regwrite;
  logic [CNT_W-1:0]       stall_q;

  // With a skid buffer in_ready is a flop; without one it looks through to out_ready.
  always_comb begin
    in_ready = 1'b0;
    if (SKID_EN) begin
      in_ready = in_ready_q;
    end else begin
      in_ready = !out_valid_q || out_ready;
    end
  end

  assign out_valid  = out_valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign payload_o  = payload_q;
  assign regwrite_o = regwrite_q;
  assign stall_cnt  = stall_q;

  // Entry FSM: every output is a register; instr/regwrite are zeroed whenever the stage empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_EMPTY;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      instr_q       <= '0;
      pc_q          <= PC_RESET;
      payload_q     <= '0;
      regwrite_q    <= 1'b0;
      skid_instr    <= '0;
      skid_pc       <= '0;
      skid_payload  <= '0;
      skid_regwrite <= 1'b0;
    end else if (flush) begin
      // pc and payload keep their last values; only the fields that matter to write-back are cleared
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      instr_q     <= '0;
      regwrite_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_valid) begin
            state       <= ST_FULL;
            out_valid_q <= 1'b1;
            instr_q     <= instr_i;
            pc_q        <= pc_i;
            payload_q   <= payload_i;
            regwrite_q  <= regwrite_i;
          end
        end
        ST_FULL: begin
          if (in_valid && out_ready) begin
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            payload_q  <= payload_i;
            regwrite_q <= regwrite_i;
          end else if (in_valid && !out_ready) begin
            if (SKID_EN) begin
              state         <= ST_SKID;
              in_ready_q    <= 1'b0;
              skid_instr    <= instr_i;
              skid_pc       <= pc_i;
              skid_payload  <= payload_i;
              skid_regwrite <= regwrite_i;
            end
          end else if (out_ready) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            regwrite_q  <= 1'b0;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            state      <= ST_FULL;
            in_ready_q <= 1'b1;
            instr_q    <= skid_instr;
            pc_q       <= skid_pc;
            payload_q  <= skid_payload;
            regwrite_q <= skid_regwrite;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          instr_q     <= '0;
          regwrite_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall counter: counts waiting cycles, sticks at all-ones, survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!flush && out_valid_q && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mem2wb_pipe_stage.sv
// tb_mem2wb_pipe_stage: drives a skid-buffer instance (4-bit stall counter) and a
// single-register instance (16-bit counter) with the same inputs and compares
// both against a queue-style reference model of the stage.
module tb_mem2wb_pipe_stage;

  localparam int          PW     = 96;
  localparam logic [31:0] PC_RST = 32'h0000_3000;

  typedef struct {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [PW-1:0] pay;
    logic          rw;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready, regwrite_i;
  logic [31:0]   instr_i, pc_i;
  logic [PW-1:0] payload_i;

  logic          a_in_ready, a_out_valid, a_regwrite;
  logic [31:0]   a_instr, a_pc;
  logic [PW-1:0] a_payload;
  logic [3:0]    a_stall;

  logic          b_in_ready, b_out_valid, b_regwrite;
  logic [31:0]   b_instr, b_pc;
  logic [PW-1:0] b_payload;
  logic [15:0]   b_stall;

  int checks   = 0;
  int failures = 0;

  // model state per instance: held entries (head at index 0), shown pc/payload, stall count
  ent_t          mq[2][2];
  int            mn[2];
  logic [31:0]   mpc[2];
  logic [PW-1:0] mpay[2];
  int            mst[2];

  always #5 clk = ~clk;

  mem2wb_pipe_stage #(.PAYLOAD_W(PW), .PC_RESET(PC_RST), .SKID_EN(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .instr_i(instr_i), .pc_i(pc_i), .payload_i(payload_i), .regwrite_i(regwrite_i),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .instr_o(a_instr), .pc_o(a_pc), .payload_o(a_payload), .regwrite_o(a_regwrite),
    .stall_cnt(a_stall)
  );

  mem2wb_pipe_stage #(.PAYLOAD_W(PW), .PC_RESET(PC_RST), .SKID_EN(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .instr_i(instr_i), .pc_i(pc_i), .payload_i(payload_i), .regwrite_i(regwrite_i),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .instr_o(b_instr), .pc_o(b_pc), .payload_o(b_payload), .regwrite_o(b_regwrite),
    .stall_cnt(b_stall)
  );

  // reference: a FIFO of capacity 2 (skid) or 1 (no skid) with handshake rules
  task automatic model_step();
    bit rdy;
    int smax;
    ent_t e;
    for (int d = 0; d < 2; d++) begin
      smax = (d == 0) ? 15 : 65535;
      rdy  = (d == 0) ? (mn[d] < 2) : (mn[d] == 0 || out_ready);
      if (reset) begin
        mn[d] = 0; mpc[d] = PC_RST; mpay[d] = '0; mst[d] = 0;
      end else if (flush) begin
        mn[d] = 0;
      end else begin
        if (mn[d] > 0 && !out_ready && mst[d] < smax) mst[d]++;
        if (mn[d] > 0 && out_ready) begin
          mq[d][0] = mq[d][1];
          mn[d]--;
        end
        if (in_valid && rdy) begin
          e.instr = instr_i; e.pc = pc_i; e.pay = payload_i; e.rw = regwrite_i;
          mq[d][mn[d]] = e;
          mn[d]++;
        end
      end
      if (mn[d] > 0) begin
        mpc[d]  = mq[d][0].pc;
        mpay[d] = mq[d][0].pay;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit rw);
    in_valid   = v;
    instr_i    = ins;
    pc_i       = pc;
    regwrite_i = rw;
    payload_i  = {$urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 10;
    if (a_pc !== PC_RST) begin failures++; $display("[TB] FAIL reset_pc_a got=%h exp=%h", a_pc, PC_RST); end
    if (a_instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr_a got=%h exp=0", a_instr); end
    if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid_a got=%b exp=0", a_out_valid); end
    if (a_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready_a got=%b exp=1", a_in_ready); end
    if (a_stall !== 4'h0) begin failures++; $display("[TB] FAIL reset_stall_a got=%0d exp=0", a_stall); end
    if (a_regwrite !== 1'b0) begin failures++; $display("[TB] FAIL reset_rw_a got=%b exp=0", a_regwrite); end
    if (a_payload !== '0) begin failures++; $display("[TB] FAIL reset_payload_a got=%h exp=0", a_payload); end
    if (b_pc !== PC_RST) begin failures++; $display("[TB] FAIL reset_pc_b got=%h exp=%h", b_pc, PC_RST); end
    if (b_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid_b got=%b exp=0", b_out_valid); end
    if (b_stall !== 16'h0) begin failures++; $display("[TB] FAIL reset_stall_b got=%0d exp=0", b_stall); end
  endtask

  task automatic test_streaming();
    logic [31:0] ins[3];
    bit          rws[3];
    ins[0] = 32'h8C01_0004; ins[1] = 32'h0022_1820; ins[2] = 32'hAC03_0008;
    rws[0] = 1'b1; rws[1] = 1'b1; rws[2] = 1'b0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ins[i], 32'h0000_3000 + 32'(4 * i), rws[i]);
      tick();
      checks += 6;
      if (a_instr !== ins[i]) begin failures++; $display("[TB] FAIL stream_instr_a[%0d] got=%h exp=%h", i, a_instr, ins[i]); end
      if (a_regwrite !== rws[i]) begin failures++; $display("[TB] FAIL stream_rw_a[%0d] got=%b exp=%b", i, a_regwrite, rws[i]); end
      if (a_pc !== 32'h0000_3000 + 32'(4 * i)) begin failures++; $display("[TB] FAIL stream_pc_a[%0d] got=%h", i, a_pc); end
      if (a_stall !== 4'h0) begin failures++; $display("[TB] FAIL stream_stall_a[%0d] got=%0d exp=0", i, a_stall); end
      if (b_instr !== ins[i]) begin failures++; $display("[TB] FAIL stream_instr_b[%0d] got=%h exp=%h", i, b_instr, ins[i]); end
      if (b_regwrite !== rws[i]) begin failures++; $display("[TB] FAIL stream_rw_b[%0d] got=%b exp=%b", i, b_regwrite, rws[i]); end
    end
    drive(1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    tick();
    checks += 3;
    if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain_valid_a got=%b exp=0", a_out_valid); end
    if (a_instr !== 32'h0) begin failures++; $display("[TB] FAIL stream_drain_instr_a got=%h exp=0", a_instr); end
    if (a_pc !== 32'h0000_3008) begin failures++; $display("[TB] FAIL stream_drain_pc_a got=%h exp=00003008", a_pc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 32'h0000_4000, 1'b1);
    tick();
    drive(1'b1, 32'hBBBB_0002, 32'h0000_4004, 1'b0);
    tick();
    checks += 5;
    if (a_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_skid_in_ready got=%b exp=0", a_in_ready); end
    if (a_instr !== 32'hAAAA_0001) begin failures++; $display("[TB] FAIL bp_hold_instr got=%h exp=aaaa0001", a_instr); end
    if (a_stall !== 4'd1) begin failures++; $display("[TB] FAIL bp_stall1 got=%0d exp=1", a_stall); end
    if (b_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_noskid_in_ready got=%b exp=0", b_in_ready); end
    if (b_instr !== 32'hAAAA_0001) begin failures++; $display("[TB] FAIL bp_noskid_hold got=%h exp=aaaa0001", b_instr); end
    drive(1'b1, 32'hCCCC_0003, 32'h0000_4008, 1'b1);
    tick();
    checks += 2;
    if (a_stall !== 4'd2) begin failures++; $display("[TB] FAIL bp_stall2 got=%0d exp=2", a_stall); end
    if (a_instr !== 32'hAAAA_0001 || a_regwrite !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold2 got=%h/%b exp=aaaa0001/1", a_instr, a_regwrite); end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    tick();
    checks += 4;
    if (a_instr !== 32'hBBBB_0002) begin failures++; $display("[TB] FAIL bp_deliver_b got=%h exp=bbbb0002", a_instr); end
    if (a_regwrite !== 1'b0) begin failures++; $display("[TB] FAIL bp_deliver_b_rw got=%b exp=0", a_regwrite); end
    if (a_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_in_ready_back got=%b exp=1", a_in_ready); end
    if (a_stall !== 4'd2) begin failures++; $display("[TB] FAIL bp_stall_after got=%0d exp=2", a_stall); end
    tick();
    checks += 1;
    if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_empty got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_0001, 32'h0000_5000, 1'b1);
    tick();
    drive(1'b1, 32'h2222_0002, 32'h0000_5004, 1'b1);
    tick();
    drive(1'b1, 32'h3333_0003, 32'h0000_5008, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    checks += 5;
    if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got=%b exp=0", a_out_valid); end
    if (a_regwrite !== 1'b0) begin failures++; $display("[TB] FAIL flush_rw got=%b exp=0", a_regwrite); end
    if (a_instr !== 32'h0) begin failures++; $display("[TB] FAIL flush_instr got=%h exp=0", a_instr); end
    if (a_stall !== 4'd1) begin failures++; $display("[TB] FAIL flush_stall got=%0d exp=1", a_stall); end
    if (a_pc !== 32'h0000_5000) begin failures++; $display("[TB] FAIL flush_pc_hold got=%h exp=00005000", a_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_deliver[%0d] got=%b exp=0", i, a_out_valid); end
      if (b_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_deliver_b[%0d] got=%b exp=0", i, b_out_valid); end
    end
  endtask

  task automatic test_saturation();
    int expb;
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h5A5A_0000, 32'h0000_6000, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      expb = (i > 15) ? 15 : i;
      checks += 1;
      if (a_stall !== 4'(expb)) begin failures++; $display("[TB] FAIL sat_stall_a[%0d] got=%0d exp=%0d", i, a_stall, expb); end
    end
    checks += 2;
    if (b_stall !== 16'd20) begin failures++; $display("[TB] FAIL sat_stall_b got=%0d exp=20", b_stall); end
    if (a_instr !== 32'h5A5A_0000) begin failures++; $display("[TB] FAIL sat_hold got=%h exp=5a5a0000", a_instr); end
  endtask

  task automatic test_noskid();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h7000_0001, 32'h0000_7000, 1'b1);
    tick();
    drive(1'b1, 32'h7000_0002, 32'h0000_7004, 1'b0);
    #1;
    checks += 1;
    if (b_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL noskid_blocked got=%b exp=0", b_in_ready); end
    out_ready = 1'b1;
    #1;
    checks += 1;
    if (b_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL noskid_comb_ready got=%b exp=1", b_in_ready); end
    tick();
    checks += 2;
    if (b_instr !== 32'h7000_0002) begin failures++; $display("[TB] FAIL noskid_accept got=%h exp=70000002", b_instr); end
    if (b_regwrite !== 1'b0) begin failures++; $display("[TB] FAIL noskid_accept_rw got=%b exp=0", b_regwrite); end
  endtask

  task automatic test_random();
    logic          ov, rw, ir;
    logic [31:0]   ins, pc;
    logic [PW-1:0] pay;
    int            st;
    ent_t          h;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) != 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        ov  = d ? b_out_valid : a_out_valid;
        ir  = d ? b_in_ready  : a_in_ready;
        ins = d ? b_instr     : a_instr;
        rw  = d ? b_regwrite  : a_regwrite;
        pc  = d ? b_pc        : a_pc;
        pay = d ? b_payload   : a_payload;
        st  = d ? int'(b_stall) : int'(a_stall);
        h   = mq[d][0];
        checks += 7;
        if (ov !== (mn[d] > 0)) begin failures++; $display("[TB] FAIL rnd_valid d%0d c%0d got=%b exp=%b", d, c, ov, mn[d] > 0); end
        if (ir !== ((d == 0) ? (mn[d] < 2) : (mn[d] == 0 || out_ready))) begin failures++; $display("[TB] FAIL rnd_in_ready d%0d c%0d got=%b", d, c, ir); end
        if (ins !== ((mn[d] > 0) ? h.instr : 32'h0)) begin failures++; $display("[TB] FAIL rnd_instr d%0d c%0d got=%h", d, c, ins); end
        if (rw !== ((mn[d] > 0) ? h.rw : 1'b0)) begin failures++; $display("[TB] FAIL rnd_rw d%0d c%0d got=%b", d, c, rw); end
        if (pc !== mpc[d]) begin failures++; $display("[TB] FAIL rnd_pc d%0d c%0d got=%h exp=%h", d, c, pc, mpc[d]); end
        if (pay !== mpay[d]) begin failures++; $display("[TB] FAIL rnd_payload d%0d c%0d got=%h exp=%h", d, c, pay, mpay[d]); end
        if (st != mst[d]) begin failures++; $display("[TB] FAIL rnd_stall d%0d c%0d got=%0d exp=%0d", d, c, st, mst[d]); end
      end
    end
    reset = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; instr_i = '0; pc_i = '0; payload_i = '0; regwrite_i = 1'b0;
    mn[0] = 0; mn[1] = 0; mst[0] = 0; mst[1] = 0;
    mpc[0] = PC_RST; mpc[1] = PC_RST; mpay[0] = '0; mpay[1] = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_noskid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
